// File: rtl/intel8080_pkg.sv
// Shared types for the 8080-style bus responders: access FSM states and bus direction codes.
package intel8080_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } mem_state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port byte RAM with synchronous read and write-first behaviour; contents are never reset.
module ram_sp_sync #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// CPU-side memory responder: address decode, wait-state insertion and a 4-phase
// rd/wr -> ack handshake in front of a synchronous single-port RAM.
module mem_responder
    import intel8080_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk50M_i,
    input  logic        rst_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    input  logic        rd_i,
    input  logic        wr_i,
    output logic [7:0]  data_o,
    output logic        data_oe_o,
    output logic        ack_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    mem_state_t        state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              dir_q;
    logic              armed_q;
    logic              ack_q;
    logic              oe_q;
    logic              busy_q;
    logic              err_q;
    logic [7:0]        data_q;

    logic              sel;
    logic              strobe_act;
    logic              start;
    logic              illegal;
    logic              ram_en;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    always_comb begin
        sel        = (addr_i[15:ADDR_W] == BASE[15:ADDR_W]);
        strobe_act = (dir_q == DIR_WRITE) ? wr_i : rd_i;
        illegal    = sel && rd_i && wr_i;
        start      = armed_q && sel && (rd_i ^ wr_i);
        ram_en     = (state_q == ST_ACCESS);
        ram_we     = ram_en && (dir_q == DIR_WRITE);
    end

    // armed_q records that both strobes were last sampled low, so a strobe
    // still held on return to IDLE cannot retrigger an access.
    always_ff @(posedge clk50M_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            dir_q   <= DIR_READ;
            armed_q <= 1'b1;
            ack_q   <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            armed_q <= !rd_i && !wr_i;
            err_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (illegal) begin
                        err_q <= 1'b1;
                    end else if (start) begin
                        addr_q  <= addr_i[ADDR_W-1:0];
                        wdata_q <= data_i;
                        dir_q   <= wr_i ? DIR_WRITE : DIR_READ;
                        cnt_q   <= WAIT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (!strobe_act) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    // ack follows one cycle into DONE, once the RAM read register is valid.
                    if (!strobe_act) begin
                        ack_q   <= 1'b0;
                        oe_q    <= 1'b0;
                        data_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        ack_q  <= 1'b1;
                        oe_q   <= (dir_q == DIR_READ);
                        data_q <= (dir_q == DIR_READ) ? ram_rdata : 8'h00;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ram_sp_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk_i   (clk50M_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign data_o    = data_q;
    assign data_oe_o = oe_q;
    assign ack_o     = ack_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule
